// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared MDU op encodings, default busy latencies and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int C_MULT_CYCLES_DEF = 5;
    localparam int C_DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational 64-bit product / quotient / remainder for the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero,
    output logic        o_commit
);

    logic [31:0]        w_b_safe;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic               w_ovf;

    // Divisor forced to 1 on zero so the dividers never see x/0; the result is discarded.
    assign o_div_zero = (i_b == 32'd0);
    assign w_b_safe   = o_div_zero ? 32'd1 : i_b;
    assign w_ovf      = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    assign w_q_s    = $signed(i_a) / $signed(w_b_safe);
    assign w_r_s    = $signed(i_a) % $signed(w_b_safe);
    assign w_q_u    = i_a / w_b_safe;
    assign w_r_u    = i_a % w_b_safe;

    assign o_commit = is_mul_op(i_op) || (is_div_op(i_op) && !o_div_zero);

    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        case (i_op)
            MDU_MULT:  {o_hi, o_lo} = w_prod_s;
            MDU_MULTU: {o_hi, o_lo} = w_prod_u;
            MDU_DIV: begin
                if (w_ovf) begin
                    o_lo = 32'h8000_0000;
                    o_hi = 32'd0;
                end else begin
                    o_lo = w_q_s;
                    o_hi = w_r_s;
                end
            end
            MDU_DIVU: begin
                o_lo = w_q_u;
                o_hi = w_r_u;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched
// Description : E-stage multiply/divide sequencer: busy window, HI/LO, D-stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic        e_mt_we,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int         C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int         C_CNT_W   = $clog2(C_MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_div_zero;
    logic               w_commit;

    mdu_arith u_arith (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_hi       (w_res_hi),
        .o_lo       (w_res_lo),
        .o_div_zero (w_div_zero),
        .o_commit   (w_commit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (r_state == S_IDLE) begin
            // Issue has priority over a same-cycle mthi/mtlo strobe.
            if (e_start) begin
                r_state <= S_RUN;
                r_cnt   <= is_div_op(e_op) ? C_CNT_W'(DIV_CYCLES) : C_CNT_W'(MULT_CYCLES);
                r_op    <= e_op;
                r_a     <= e_a;
                r_b     <= e_b;
            end else if (e_mt_we) begin
                if (e_op == MDU_MTHI) r_hi <= e_a;
                if (e_op == MDU_MTLO) r_lo <= e_a;
            end
        end else begin
            if (r_cnt == C_CNT_W'(1)) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                if (w_commit) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else begin
                r_cnt <= r_cnt - C_CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = d_md_use & (busy | e_start);

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sched
// Description : Self-checking bench for mdu_sched: vector table, random ops vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int C_MULT = 5;
    localparam int C_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_start;
    logic [2:0]  e_op;
    logic        e_mt_we;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_md_use;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_sched #(.MULT_CYCLES(C_MULT), .DIV_CYCLES(C_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_start   (e_start),
        .e_op      (e_op),
        .e_mt_we   (e_mt_we),
        .e_a       (e_a),
        .e_b       (e_b),
        .d_md_use  (d_md_use),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall_req (stall_req)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Architectural reference: HI/LO effect of one op from plain integer arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MDU_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; e_start = 1'b0; e_mt_we = 1'b0; e_op = 3'd0; e_a = 0; e_b = 0;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        e_mt_we = 1'b1; e_op = op; e_a = v;
        @(negedge clk);
        e_mt_we = 1'b0;
        if (op == MDU_MTHI) m_hi = v; else m_lo = v;
    endtask

    // Issues one op, measures the busy window and returns the stall cycles seen.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic mtwe, output int stalls);
        int cyc;
        stalls = 0;
        @(negedge clk);
        e_start = 1'b1; e_op = op; e_a = a; e_b = b; e_mt_we = mtwe;
        #1;
        if (stall_req) stalls++;
        @(negedge clk);
        e_start = 1'b0; e_mt_we = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (stall_req) stalls++;
            @(negedge clk);
        end
        if (stall_req) stalls++;
        model_op(op, a, b);
        check({tag, " cycles"}, 64'(cyc), 64'(is_div_op(op) ? C_DIV : C_MULT));
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int          st;
        int          cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, C_MULT};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, C_MULT};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, C_DIV};
        vecs[3] = '{MDU_DIVU,  32'd7, 32'd0, 32'h1234, 32'h5678, 32'h1234, 32'h5678, C_DIV};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'h8000_0000, C_DIV};
        vecs[5] = '{MDU_DIVU,  32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, C_DIV};

        d_md_use = 1'b0;
        do_reset();
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(stall_req), 64'd0);

        for (int i = 0; i < 6; i++) begin
            mt_write(MDU_MTHI, vecs[i].pre_hi);
            mt_write(MDU_MTLO, vecs[i].pre_lo);
            check($sformatf("vec%0d pre_hi", i), 64'(hi), 64'(vecs[i].pre_hi));
            @(negedge clk);
            e_start = 1'b1; e_op = vecs[i].op; e_a = vecs[i].a; e_b = vecs[i].b;
            @(negedge clk);
            e_start = 1'b0;
            cyc = 0;
            while (busy && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            check($sformatf("vec%0d cycles", i), 64'(cyc), 64'(vecs[i].cyc));
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            m_hi = hi === vecs[i].exp_hi ? vecs[i].exp_hi : vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // Stall window covers the issue cycle plus the whole busy window.
        d_md_use = 1'b1;
        run_op("stall mult", MDU_MULT, 32'd3, 32'd4, 1'b0, st);
        check("stall cycles", 64'(st), 64'(C_MULT + 1));
        check("stall after", 64'(stall_req), 64'd0);
        d_md_use = 1'b0;

        // Same-edge issue and mt write: the strobe must be dropped.
        mt_write(MDU_MTHI, 32'hAAAA_5555);
        run_op("start+mtwe", MDU_MULTU, 32'd6, 32'd7, 1'b1, st);

        // Reset during busy cycle 4 of a divide.
        d_md_use = 1'b1;
        @(negedge clk);
        e_start = 1'b1; e_op = MDU_DIV; e_a = 32'd50; e_b = 32'd5;
        @(negedge clk);
        e_start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort stall", 64'(stall_req), 64'd0);
        d_md_use = 1'b0;
        repeat (12) @(negedge clk);
        check("abort no commit lo", 64'(lo), 64'd0);

        // Randomized ops and mt writes against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 4) == 0)
                mt_write(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom);
            d_md_use = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0, st);
            if (d_md_use)
                check($sformatf("rand%0d stall", i), 64'(st),
                      64'(is_div_op(rop) ? C_DIV + 1 : C_MULT + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
